// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one functional-unit result per cycle in
// round-robin order and broadcasts its tag and value on a registered bus.
// cdb_o packs {valid, tag, data} with valid in the MSB.

`ifndef NUM_SRBITS
`define NUM_SRBITS 8
`endif

module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = `NUM_SRBITS,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*TAG_W-1:0]    tag_i,
  input  logic [NUM_REQ*DATA_W-1:0]   val_i,
  output logic [NUM_REQ-1:0]          grant,
  output logic [TAG_W+DATA_W:0]       cdb_o,
  output logic                        tag_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] tag_nz;
  logic [NUM_REQ-1:0] eligible;
  logic               zero_req;
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [TAG_W-1:0]   win_tag;
  logic [DATA_W-1:0]  win_val;

  // Per-requester tag-nonzero flags; tag 0 marks an invalid result.
  always_comb begin
    tag_nz = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tag_nz[i] = |tag_i[i*TAG_W +: TAG_W];
    end
  end

  // A unit granted last cycle is masked so its still-held request is not granted twice.
  assign eligible = req & tag_nz & ~grant;
  assign zero_req = |(req & ~tag_nz);

  // Round-robin search: first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found     = 1'b0;
    win       = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    ptr_nxt   = PTR_W'((int'(win) + 1) % NUM_REQ);
    grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
    win_tag   = tag_i[int'(win)*TAG_W +: TAG_W];
    win_val   = val_i[int'(win)*DATA_W +: DATA_W];
  end

  // Registered grant/broadcast, pointer update and sticky tag-error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= '0;
      cdb_o   <= '0;
      rr_ptr  <= '0;
      tag_err <= 1'b0;
    end else begin
      if (!flush && zero_req) begin
        tag_err <= 1'b1;
      end
      if (flush || !found) begin
        grant <= '0;
        cdb_o <= '0;
      end else begin
        grant  <= grant_nxt;
        cdb_o  <= {1'b1, win_tag, win_val};
        rr_ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed request patterns push expected
// broadcasts (grant, tag, data, cycle) into a queue; a monitor pops and
// compares every time the bus shows valid.

module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [3:0]   req = '0;
  logic [31:0]  tag_i = '0;
  logic [127:0] val_i = '0;
  logic [3:0]   grant;
  logic [40:0]  cdb_o;
  logic         tag_err;

  typedef struct {
    logic [3:0]  g;
    logic [7:0]  t;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  tb_tag[4];
  logic [31:0] tb_val[4];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  cdb_arbiter #(.NUM_REQ(4), .TAG_W(8), .DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .req     (req),
    .tag_i   (tag_i),
    .val_i   (val_i),
    .grant   (grant),
    .cdb_o   (cdb_o),
    .tag_err (tag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < 4; i++) begin
      tag_i[i*8 +: 8]   = tb_tag[i];
      val_i[i*32 +: 32] = tb_val[i];
    end
  endtask

  task automatic push(input int f, input int c);
    exp_t e;
    e.g = 4'b0001 << f;
    e.t = tb_tag[f];
    e.d = tb_val[f];
    e.c = c;
    sb.push_back(e);
  endtask

  // Monitor: counts edges, checks bus invariants, pops expectations on valid.
  always @(posedge clk) begin
    exp_t e;
    #2;
    cyc++;
    chk("valid_eq_or_grant", 64'(cdb_o[40]), 64'(|grant));
    chk("grant_onehot", 64'($countones(grant) <= 1), 64'(1));
    if (cdb_o[40]) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bcast: got grant=%b tag=%0h at cyc %0d, expected none", grant, cdb_o[39:32], cyc);
      end else begin
        e = sb.pop_front();
        chk("grant", 64'(grant), 64'(e.g));
        chk("cdb_tag", 64'(cdb_o[39:32]), 64'(e.t));
        chk("cdb_data", 64'(cdb_o[31:0]), 64'(e.d));
        chk("bcast_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  initial begin
    tb_tag = '{8'h11, 8'h22, 8'h33, 8'h89};
    tb_val = '{32'hA0A0_0000, 32'hB1B1_0001, 32'hC2C2_0002, 32'h0000_1234};
    pack();
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_cdb", 64'(cdb_o), 64'(0));
    chk("rst_tag_err", 64'(tag_err), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // single requester FU3
    req = 4'b1000;
    push(3, cyc + 1);
    @(negedge clk);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // all four held: rotate 0,1,2,3 twice
    req = 4'b1111;
    for (int k = 0; k < 8; k++) push(k % 4, cyc + 1 + k);
    repeat (8) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);

    // FU0 and FU2, each drops on grant
    req = 4'b0101;
    push(0, cyc + 1);
    push(2, cyc + 2);
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    // single FU1 held: granted every second cycle (rr_ptr=3 here)
    req = 4'b0010;
    push(1, cyc + 1);
    push(1, cyc + 3);
    repeat (4) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);

    // flush at the arbitration edge (rr_ptr=2 here)
    req = 4'b0011;
    flush = 1'b1;
    push(0, cyc + 2);
    push(1, cyc + 3);
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);

    // tag 0 request: never granted, sticky error survives flush
    tb_tag[0] = 8'h00;
    pack();
    req = 4'b0001;
    @(negedge clk);
    chk("tag0_no_grant", 64'(grant), 64'(0));
    chk("tag0_err_set", 64'(tag_err), 64'(1));
    req = 4'b0000;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("tag_err_after_flush", 64'(tag_err), 64'(1));
    tb_tag[0] = 8'h11;
    pack();

    // async reset mid-broadcast, then arbitration restarts from index 0 (rr_ptr=2 here)
    req = 4'b0100;
    push(2, cyc + 1);
    @(posedge clk);
    #3;
    chk("bcast_before_rst", 64'(cdb_o[40]), 64'(1));
    rst = 1'b1;
    #1;
    chk("async_rst_cdb", 64'(cdb_o), 64'(0));
    chk("async_rst_grant", 64'(grant), 64'(0));
    chk("async_rst_tag_err", 64'(tag_err), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req = 4'b1010;
    push(1, cyc + 1);
    @(negedge clk);
    req = 4'b1000;
    push(3, cyc + 1);
    @(negedge clk);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of functional-unit requesters (index 0 ALU, 1 MEM, 2 MULDIV, 3 BRANCH).
REQ-002 Parameter TAG_W, default `NUM_SRBITS (8), reservation-station tag width.
REQ-003 Parameter DATA_W, default 32, broadcast value width.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  pipeline flush, synchronous.
REQ-007 req  input  NUM_REQ  per-FU CDB request (FU cdb_request).
REQ-008 tag_i  input  NUM_REQ*TAG_W  per-FU result tag, slice i = bits [i*TAG_W +: TAG_W].
REQ-009 val_i  input  NUM_REQ*DATA_W  per-FU result value, slice i as for tag_i.
REQ-010 grant  output  NUM_REQ  one-hot grant pulse, registered.
REQ-011 cdb_o  output  cdb_bus_t  registered broadcast: valid, tag (TAG_W), data (DATA_W).
REQ-012 tag_err  output  1  sticky flag: a request carried tag 0.

Function
REQ-013 Arbitration SHALL run every cycle over eligible requesters; eligible(i) = req[i] && tag_i[i] != 0 && !grant[i].
REQ-014 Masking by grant[i] SHALL prevent double grant while FU i still holds req during the grant cycle.
REQ-015 Winner SHALL be the first eligible index at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-016 rr_ptr (log2 NUM_REQ bits) SHALL load (winner+1) mod NUM_REQ on every grant; unchanged when no winner.
REQ-017 Latency: request sampled at edge k SHALL appear as cdb_o.valid=1, cdb_o.tag=tag_i[w], cdb_o.data=val_i[w], grant[w]=1 during cycle k..k+1 (one-cycle registered).
REQ-018 Without a winner at an edge, cdb_o.valid, cdb_o.tag, cdb_o.data and grant SHALL all register 0.
REQ-019 At most one grant bit SHALL be high per cycle; cdb_o.valid SHALL equal |grant.
REQ-020 grant and cdb_o SHALL be pure register outputs, no combinational path from req/tag_i/val_i.
REQ-021 Requester contract: FU keeps req, tag and value stable until it observes grant; arbiter SHALL tolerate req dropping without grant (no grant issued).
REQ-022 A request with tag 0 SHALL never be granted and SHALL set tag_err, held until rst.
REQ-023 Fairness: an eligible continuously-requesting FU SHALL be granted within NUM_REQ grants.
REQ-024 Single requester continuously eligible SHALL be granted every second cycle (grant masking).
REQ-025 flush at an edge SHALL register grant=0 and cdb_o all-zero, ignore that cycle's requests, and keep rr_ptr.
REQ-026 flush SHALL NOT clear tag_err.

Reset
REQ-027 rst high SHALL asynchronously force grant=0, cdb_o.valid=0, cdb_o.tag=0, cdb_o.data=0, rr_ptr=0, tag_err=0.
REQ-028 rst asserted mid-broadcast SHALL drop cdb_o.valid immediately; the in-flight result is lost and not replayed.
REQ-029 First arbitration after rst release SHALL start from index 0.

Verification
REQ-030 After reset, req=4'b1000, tag3=8'h89, val3=32'h0000_1234 -> next cycle grant=4'b1000, cdb_o={1,8'h89,32'h1234}; following cycle valid=0.
REQ-031 req=4'b1111 held, rr_ptr=0 -> grants in order 0001,0010,0100,1000, then repeat; cdb_o.tag tracks each FU tag.
REQ-032 req=4'b0101 with FU0 dropping req on seeing grant -> grant 0001 then 0100 in consecutive cycles, then idle.
REQ-033 req=4'b0001, tag0=8'h00 -> no grant, cdb_o.valid=0, tag_err=1 and stays 1 after flush.
REQ-034 req=4'b0011, flush high at the arbitration edge -> cdb_o.valid=0 that cycle; FU0 granted next cycle, rr_ptr unaffected.
REQ-035 rst asserted while cdb_o.valid=1 -> valid=0 without clock edge; after release req=4'b1010 -> grant=4'b0010 first.
